instruction_sequencer: RTL
==========================

# instruction_sequencer

Issues one instruction at a time to the control decoder and generates its one-hot timestep vector `T`. The block advances `T` each clock and retires the instruction when the decoder raises `done`; a watchdog forces retirement if `done` never arrives. It sits between the instruction source (switches or memory) and the control decoder, and it drives `opcode/p1/p2/p3/T` while consuming `done`.

## Interface
- `STEPS`, default 5: width of `T`, which is also the maximum number of timesteps per instruction (valid range 2..8).
- `clock` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low; 0 clears all state immediately.
- `instr_valid` input 1: source offers an instruction on `instr`.
- `instr` input 12: fields are `[11:9]` opcode, `[8:6]` p1, `[5:3]` p2, `[2:0]` p3.
- `done` input 1: decoder reports that the current instruction is complete.
- `clear_fault` input 1: synchronous clear of `fault`.
- `instr_ready` output 1: high in IDLE only; the sequencer can accept an instruction.
- `T` output STEPS: one-hot timestep; all zeros when no step is active.
- `opcode`, `p1`, `p2`, `p3` output 3 each: latched fields of the current or last instruction.
- `busy` output 1: high in EXEC or RETIRE.
- `fault` output 1: sticky flag, set when an instruction timed out.
- `retired` output 8: count of instructions retired by `done`.

## Operation
- States are IDLE, EXEC and RETIRE. All outputs are registered except `instr_ready` and `busy`, which decode directly from the state.
- Reset values: state IDLE, `T`=0, `opcode/p1/p2/p3`=0, `fault`=0, `retired`=0. With these, `instr_ready`=1 and `busy`=0.
- **IDLE:**
  - If `instr_valid`=1 at the edge, latch all four fields, set `T`=1 (bit 0) and go to EXEC.
  - Otherwise hold all outputs.
- **EXEC:** at each edge, check these in priority order.
  1. If `done`=1: set `T`=0, increment `retired` (modulo 256, 255 wraps to 0) and go to RETIRE.
  2. Else if `T[STEPS-1]`=1 (timeout): set `T`=0, set `fault`=1, leave `retired` unchanged and go to RETIRE.
  3. Otherwise shift `T` left by one.
- **RETIRE:** lasts exactly one cycle with `T`=0, then goes to IDLE. The cycle guarantees the decoder sees `T`=0 before the next instruction starts.
- `done` is ignored outside EXEC.
- `instr_valid` is ignored outside IDLE. The source must hold `instr` stable until it sees `instr_ready` and `instr_valid` both high at an edge.
- Latched fields hold through RETIRE and IDLE, changing only when a new instruction is accepted.
- `fault` clears on an edge where `clear_fault`=1. If a timeout occurs on the same edge as `clear_fault`, the set wins and `fault`=1.
- Reset asserted mid-EXEC returns the block to reset values immediately, without waiting for a clock edge. The aborted instruction is neither counted nor faulted.

## Timing
- Instruction accepted at edge k: `T`=0b00001 after edge k.
- A `done` sampled high at edge k+n (seen while `T` bit n-1 is high) gives:
  - `T`=0 after edge k+n;
  - `instr_ready`=1 after edge k+n+1;
  - the earliest next accept at edge k+n+1.
- Instruction period is therefore n+1 cycles, where n is the number of active steps. The minimum period is 2 cycles (`done` seen in step `T[0]`).
- Timeout: with no `done`, `T` walks bits 0..STEPS-1 over STEPS cycles. The fault is taken at the edge ending the `T[STEPS-1]` cycle, and the total period is STEPS+1 cycles.
- `done` may be combinational from `T`; the sequencer samples it only at the clock edge.

## Test plan
- **Reset:** drive `reset`=0 mid-cycle → all outputs are at reset values before the next edge; `instr_ready`=1.
- **Two-step instruction:** accept `instr`=0x0A3 (opcode 0, p1 2, p2 4, p3 3); drive `done`=1 while `T`=0b00010 → `T` sequence is 00001, 00010, 00000; `retired` goes 0→1; `instr_ready` returns 3 cycles after accept; fields stay latched afterward.
- **Four-step instruction:** accept opcode 3 with `done`=1 during `T`=0b01000 → `T` is 1, 2, 4, 8 then 0; `retired` increments; `fault` stays 0.
- **Timeout:** accept opcode 7 with `done` held 0 → `T` walks to 0b10000, then `fault`=1 and `retired` is unchanged. Pulse `clear_fault` → `fault`=0.
- **Back-to-back and ignore rules:** hold `instr_valid`=1 continuously → each new accept happens only in IDLE. `done` pulsed in IDLE or RETIRE → `retired` is unchanged.
- **Wrap and abort:** retire 256 instructions → `retired` wraps to 0. Assert reset during `T`=0b00100 → state returns to IDLE, `T`=0, `retired`=0.

Source files
------------

// File: rtl/instruction_sequencer.sv
// Issues one instruction at a time to the control decoder and walks a one-hot
// timestep vector T until the decoder reports done or the step budget runs out.
module instruction_sequencer #(
    parameter int STEPS = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [11:0]      instr,
    input  logic             done,
    input  logic             clear_fault,
    output logic             instr_ready,
    output logic [STEPS-1:0] T,
    output logic [2:0]       opcode,
    output logic [2:0]       p1,
    output logic [2:0]       p2,
    output logic [2:0]       p3,
    output logic             busy,
    output logic             fault,
    output logic [7:0]       retired,
    output logic [1:0]       dbg_state_o
);

    // Handshake: an instruction transfers on an edge where instr_valid and
    // instr_ready are both high; instr_ready is high only in IDLE, so the
    // source must hold instr stable until that edge.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_RETIRE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [STEPS-1:0] t_q, t_d;
    logic [2:0]       opcode_q, opcode_d;
    logic [2:0]       p1_q, p1_d;
    logic [2:0]       p2_q, p2_d;
    logic [2:0]       p3_q, p3_d;
    logic             fault_q, fault_d;
    logic [7:0]       retired_q, retired_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            t_q       <= '0;
            opcode_q  <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            p3_q      <= '0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            t_q       <= t_d;
            opcode_q  <= opcode_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            p3_q      <= p3_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        t_d       = t_q;
        opcode_d  = opcode_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        p3_d      = p3_q;
        retired_d = retired_q;
        // A timeout below overrides this clear on the same edge.
        fault_d   = clear_fault ? 1'b0 : fault_q;

        unique case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    opcode_d = instr[11:9];
                    p1_d     = instr[8:6];
                    p2_d     = instr[5:3];
                    p3_d     = instr[2:0];
                    t_d      = STEPS'(1);
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (done) begin
                    t_d       = '0;
                    retired_d = retired_q + 8'd1;
                    state_d   = S_RETIRE;
                end else if (t_q[STEPS-1]) begin
                    t_d     = '0;
                    fault_d = 1'b1;
                    state_d = S_RETIRE;
                end else begin
                    t_d = t_q << 1;
                end
            end
            S_RETIRE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                t_d     = '0;
            end
        endcase
    end

    assign instr_ready = (state_q == S_IDLE);
    assign busy        = (state_q == S_EXEC) || (state_q == S_RETIRE);
    assign T           = t_q;
    assign opcode      = opcode_q;
    assign p1          = p1_q;
    assign p2          = p2_q;
    assign p3          = p3_q;
    assign fault       = fault_q;
    assign retired     = retired_q;
    assign dbg_state_o = state_q;

endmodule
